// File: rtl/instr_fetch_sequencer_if.sv
// Avalon-style instruction read bus between the fetch sequencer (master) and memory (slave).
interface instr_fetch_sequencer_if;
   logic [31:0] mem_address;
   logic        mem_read;
   logic        mem_waitrequest;
   logic [31:0] mem_readdata;

   modport master (output mem_address, mem_read, input mem_waitrequest, mem_readdata);
   modport slave  (input mem_address, mem_read, output mem_waitrequest, mem_readdata);
endinterface

// File: rtl/instr_fetch_sequencer.sv
// Fetch/exec phase sequencer, instruction register and PC (with delay slot) for the multicycle MIPS core.
// Optional macro FETCH_TIMEOUT_EN adds a FETCH waitrequest timeout with sticky fetch_timeout flag.
//
//   state  | meaning
//   HALTED | stopped after jump to 0 (or fetch timeout); absorbing until reset
//   FETCH  | bus read at pc, wait out mem_waitrequest
//   EXEC1  | first execute phase, always one cycle
//   EXEC2  | second execute phase, held by stall; PC update on completion
module instr_fetch_sequencer #(
   parameter logic [31:0] RESET_VECTOR   = 32'hBFC0_0000,
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic                    clk,
   input  logic                    reset_n,
   instr_fetch_sequencer_if.master mem,
   input  logic                    stall,
   input  logic                    pc_load,
   input  logic [31:0]             pc_next,
   output logic                    fetch,
   output logic                    exec_one,
   output logic                    exec_two,
   output logic [31:0]             current_instruction,
   output logic [31:0]             pc,
   output logic                    active,
   output logic                    fetch_timeout
);

   typedef enum logic [1:0] {S_HALTED, S_FETCH, S_EXEC1, S_EXEC2} state_t;

   state_t      state_q, state_d;
   logic [31:0] pc_q, pc_d;
   logic [31:0] instr_q, instr_d;
   logic        active_q, active_d;
   logic        pend_q, pend_d;
   logic [31:0] tgt_q, tgt_d;
   logic [31:0] new_pc;
   logic        unused_pc_next_lsbs;

   if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
      $error("TIMEOUT_CYCLES must be nonzero");
   end

`ifdef FETCH_TIMEOUT_EN
   localparam int unsigned CntW = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic            timeout_q, timeout_d;
`endif

   assign unused_pc_next_lsbs = ^pc_next[1:0];

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q  <= S_FETCH;
         pc_q     <= RESET_VECTOR;
         instr_q  <= '0;
         active_q <= 1'b1;
         pend_q   <= 1'b0;
         tgt_q    <= '0;
      end else begin
         state_q  <= state_d;
         pc_q     <= pc_d;
         instr_q  <= instr_d;
         active_q <= active_d;
         pend_q   <= pend_d;
         tgt_q    <= tgt_d;
      end
   end

`ifdef FETCH_TIMEOUT_EN
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cnt_q     <= '0;
         timeout_q <= 1'b0;
      end else begin
         cnt_q     <= cnt_d;
         timeout_q <= timeout_d;
      end
   end
`endif

   always_comb begin
      state_d  = state_q;
      pc_d     = pc_q;
      instr_d  = instr_q;
      active_d = active_q;
      pend_d   = pend_q;
      tgt_d    = tgt_q;
      new_pc   = pend_q ? tgt_q : pc_q + 32'd4;
`ifdef FETCH_TIMEOUT_EN
      cnt_d     = '0;
      timeout_d = timeout_q;
`endif
      case (state_q)
         S_FETCH: begin
            if (!mem.mem_waitrequest) begin
               instr_d = mem.mem_readdata;
               state_d = S_EXEC1;
            end
`ifdef FETCH_TIMEOUT_EN
            else if (cnt_q + CntW'(1) == CntW'(TIMEOUT_CYCLES)) begin
               state_d   = S_HALTED;
               active_d  = 1'b0;
               timeout_d = 1'b1;
            end else begin
               cnt_d = cnt_q + CntW'(1);
            end
`endif
         end
         S_EXEC1: state_d = S_EXEC2;
         S_EXEC2: begin
            if (!stall) begin
               // a branch in the delay slot applies the old target now and queues the new one
               if (pc_load) begin
                  tgt_d  = {pc_next[31:2], 2'b00};
                  pend_d = 1'b1;
               end else begin
                  pend_d = 1'b0;
               end
               if (new_pc == 32'd0) begin
                  pc_d     = 32'd0;
                  state_d  = S_HALTED;
                  active_d = 1'b0;
               end else begin
                  pc_d    = new_pc;
                  state_d = S_FETCH;
               end
            end
         end
         default: state_d = S_HALTED;
      endcase
   end

   assign fetch               = (state_q == S_FETCH);
   assign exec_one            = (state_q == S_EXEC1);
   assign exec_two            = (state_q == S_EXEC2);
   assign mem.mem_read        = fetch;
   assign mem.mem_address     = pc_q;
   assign current_instruction = instr_q;
   assign pc                  = pc_q;
   assign active              = active_q;
`ifdef FETCH_TIMEOUT_EN
   assign fetch_timeout       = timeout_q;
`else
   assign fetch_timeout       = 1'b0;
`endif

endmodule
